// File: rtl/cluster_dma_pkg.sv
// Shared cluster DMA types: the 2D transfer descriptor and flag bit positions.
package cluster_dma_pkg;

    // Bit positions inside the 3-bit flag field {deburst, decouple, serialize}
    localparam int unsigned DEBURST   = 2;
    localparam int unsigned DECOUPLE  = 1;
    localparam int unsigned SERIALIZE = 0;

    typedef logic [2:0] dma_flags_t;

    // Arbitrated 2D transfer descriptor as produced by the frontend
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] num_bytes;
        logic [31:0] src_stride;
        logic [31:0] dst_stride;
        logic [31:0] num_reps;
        logic        is_2d;
        dma_flags_t  flags;
    } twod_req_t;

endpackage

// File: rtl/cluster_dma_twod_midend.sv
// 2D-to-1D midend: splits one 2D descriptor into num_reps strided 1D bursts.
// All outputs come from registers; only in_ready_o looks at out_ready_i so a
// new descriptor can be taken on the final-burst handshake without a bubble.
module cluster_dma_twod_midend
    import cluster_dma_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned NumBytesWidth = 32,
    parameter int unsigned RepWidth      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [AddrWidth-1:0]     in_src_i,
    input  logic [AddrWidth-1:0]     in_dst_i,
    input  logic [NumBytesWidth-1:0] in_num_bytes_i,
    input  logic [AddrWidth-1:0]     in_src_stride_i,
    input  logic [AddrWidth-1:0]     in_dst_stride_i,
    input  logic [RepWidth-1:0]      in_num_reps_i,
    input  logic                     in_is_2d_i,
    input  logic [2:0]               in_flags_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [AddrWidth-1:0]     out_src_o,
    output logic [AddrWidth-1:0]     out_dst_o,
    output logic [NumBytesWidth-1:0] out_num_bytes_o,
    output logic [2:0]               out_flags_o,
    output logic                     out_last_o,
    output logic                     busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [AddrWidth-1:0]     src_q, src_d;
    logic [AddrWidth-1:0]     dst_q, dst_d;
    logic [NumBytesWidth-1:0] num_bytes_q, num_bytes_d;
    logic [AddrWidth-1:0]     src_stride_q, src_stride_d;
    logic [AddrWidth-1:0]     dst_stride_q, dst_stride_d;
    logic [RepWidth-1:0]      reps_q, reps_d;
    dma_flags_t               flags_q, flags_d;

    logic is_busy;
    logic is_last;
    logic out_hs;
    logic in_hs;

    // Handshake decode; ready reopens on the final burst for back-to-back transfers
    always_comb begin
        is_busy    = (state_q == BUSY);
        is_last    = is_busy && (reps_q == RepWidth'(1));
        out_hs     = is_busy && out_ready_i;
        in_ready_o = !is_busy || (out_hs && is_last);
        in_hs      = in_valid_i && in_ready_o;
    end

    // Next-state: load a descriptor, step addresses per burst, or fall back to IDLE
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        num_bytes_d  = num_bytes_q;
        src_stride_d = src_stride_q;
        dst_stride_d = dst_stride_q;
        reps_d       = reps_q;
        flags_d      = flags_q;

        if (in_hs) begin
            state_d      = BUSY;
            src_d        = in_src_i;
            dst_d        = in_dst_i;
            num_bytes_d  = in_num_bytes_i;
            src_stride_d = in_src_stride_i;
            dst_stride_d = in_dst_stride_i;
            flags_d      = in_flags_i;
            if (!in_is_2d_i || (in_num_reps_i == '0)) begin
                reps_d = RepWidth'(1);
            end else begin
                reps_d = in_num_reps_i;
            end
        end else if (out_hs && is_last) begin
            state_d = IDLE;
        end else if (out_hs) begin
            src_d  = src_q + src_stride_q;
            dst_d  = dst_q + dst_stride_q;
            reps_d = reps_q - RepWidth'(1);
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            num_bytes_q  <= '0;
            src_stride_q <= '0;
            dst_stride_q <= '0;
            reps_q       <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            num_bytes_q  <= num_bytes_d;
            src_stride_q <= src_stride_d;
            dst_stride_q <= dst_stride_d;
            reps_q       <= reps_d;
            flags_q      <= flags_d;
        end
    end

    // Outputs straight from the registers
    always_comb begin
        out_valid_o     = is_busy;
        out_last_o      = is_last;
        busy_o          = is_busy;
        out_src_o       = src_q;
        out_dst_o       = dst_q;
        out_num_bytes_o = num_bytes_q;
        out_flags_o     = flags_q;
    end

endmodule

// File: tb/tb_cluster_dma_twod_midend.sv
// Self-checking bench for cluster_dma_twod_midend: directed and random 2D
// descriptors compared against an arithmetic model of the burst sequence.
module tb_cluster_dma_twod_midend;
    import cluster_dma_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_src_i = '0;
    logic [31:0] in_dst_i = '0;
    logic [31:0] in_num_bytes_i = '0;
    logic [31:0] in_src_stride_i = '0;
    logic [31:0] in_dst_stride_i = '0;
    logic [31:0] in_num_reps_i = '0;
    logic        in_is_2d_i = 1'b0;
    logic [2:0]  in_flags_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_src_o;
    logic [31:0] out_dst_o;
    logic [31:0] out_num_bytes_o;
    logic [2:0]  out_flags_o;
    logic        out_last_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    cluster_dma_twod_midend #(
        .AddrWidth(32),
        .NumBytesWidth(32),
        .RepWidth(32)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_src_i(in_src_i),
        .in_dst_i(in_dst_i),
        .in_num_bytes_i(in_num_bytes_i),
        .in_src_stride_i(in_src_stride_i),
        .in_dst_stride_i(in_dst_stride_i),
        .in_num_reps_i(in_num_reps_i),
        .in_is_2d_i(in_is_2d_i),
        .in_flags_i(in_flags_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_src_o(out_src_o),
        .out_dst_o(out_dst_o),
        .out_num_bytes_o(out_num_bytes_o),
        .out_flags_o(out_flags_o),
        .out_last_o(out_last_o),
        .busy_o(busy_o)
    );

    // Free-running clock, active edge at posedge
    always #5 clk_i = ~clk_i;

    // Reference model: number of 1D bursts a descriptor expands into
    function automatic int nbursts(input twod_req_t d);
        if (!d.is_2d || d.num_reps == 0) return 1;
        return int'(d.num_reps);
    endfunction

    // Reference model: k-th burst address is base + k*stride modulo 2^32
    function automatic logic [31:0] addr_at(input logic [31:0] base, input logic [31:0] stride, input int k);
        logic [63:0] full;
        full = 64'(base) + 64'(k) * 64'(stride);
        return full[31:0];
    endfunction

    function automatic twod_req_t make_desc(input logic [31:0] src, input logic [31:0] dst,
                                            input logic [31:0] nb, input logic [31:0] ss,
                                            input logic [31:0] ds, input logic [31:0] reps,
                                            input logic is2d, input logic [2:0] fl);
        twod_req_t d;
        d.src = src; d.dst = dst; d.num_bytes = nb; d.src_stride = ss;
        d.dst_stride = ds; d.num_reps = reps; d.is_2d = is2d; d.flags = fl;
        return d;
    endfunction

    function automatic twod_req_t rand_desc();
        twod_req_t d;
        d.src        = $urandom;
        d.dst        = $urandom;
        d.num_bytes  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        d.src_stride = $urandom;
        d.dst_stride = $urandom;
        d.num_reps   = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 5));
        d.is_2d      = ($urandom_range(0, 3) != 0);
        d.flags      = 3'($urandom_range(0, 7));
        if (d.is_2d && d.num_reps > 6) d.num_reps = 32'd6;
        return d;
    endfunction

    task automatic drive_desc(input twod_req_t d);
        in_src_i        = d.src;
        in_dst_i        = d.dst;
        in_num_bytes_i  = d.num_bytes;
        in_src_stride_i = d.src_stride;
        in_dst_stride_i = d.dst_stride;
        in_num_reps_i   = d.num_reps;
        in_is_2d_i      = d.is_2d;
        in_flags_i      = d.flags;
    endtask

    // Walks the bursts of an accepted descriptor, optionally stalling and chaining the next one
    task automatic stream(input twod_req_t d, input bit has_next, input twod_req_t nd,
                          input int max_stall, input int fixed_k, input int fixed_n, input string tag);
        int n;
        int stalls;
        bit rdy;
        bit lst;
        n = nbursts(d);
        for (int k = 0; k < n; k++) begin
            stalls = (k == fixed_k) ? fixed_n : $urandom_range(0, max_stall);
            for (int c = 0; c <= stalls; c++) begin
                rdy = (c == stalls);
                lst = (k == n - 1);
                out_ready_i = rdy;
                if (rdy && lst && has_next) begin
                    drive_desc(nd);
                    in_valid_i = 1'b1;
                end else begin
                    in_valid_i = 1'b0;
                end
                #1;
                checks++;
                if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s valid/busy k=%0d: got %b/%b want 1/1", tag, k, out_valid_o, busy_o);
                end
                checks++;
                if (out_src_o !== addr_at(d.src, d.src_stride, k) || out_dst_o !== addr_at(d.dst, d.dst_stride, k)) begin
                    errors++;
                    $display("[TB] FAIL %s addr k=%0d: got %h/%h want %h/%h", tag, k, out_src_o, out_dst_o,
                             addr_at(d.src, d.src_stride, k), addr_at(d.dst, d.dst_stride, k));
                end
                checks++;
                if (out_num_bytes_o !== d.num_bytes || out_flags_o !== d.flags) begin
                    errors++;
                    $display("[TB] FAIL %s bytes/flags k=%0d: got %h/%b want %h/%b", tag, k, out_num_bytes_o, out_flags_o, d.num_bytes, d.flags);
                end
                checks++;
                if (out_last_o !== lst) begin
                    errors++;
                    $display("[TB] FAIL %s last k=%0d: got %b want %b", tag, k, out_last_o, lst);
                end
                checks++;
                if (in_ready_o !== (rdy && lst)) begin
                    errors++;
                    $display("[TB] FAIL %s in_ready k=%0d: got %b want %b", tag, k, in_ready_o, rdy && lst);
                end
                @(negedge clk_i);
            end
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        if (!has_next) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s idle after last: got valid=%b busy=%b in_ready=%b want 0/0/1", tag, out_valid_o, busy_o, in_ready_o);
            end
        end
    endtask

    // Presents a descriptor from IDLE and expects acceptance in that cycle
    task automatic send(input twod_req_t d, input int max_stall, input int fixed_k, input int fixed_n, input string tag);
        twod_req_t none;
        none = '0;
        @(negedge clk_i);
        drive_desc(d);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s accept: got in_ready=%b valid=%b want 1/0", tag, in_ready_o, out_valid_o);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        stream(d, 1'b0, none, max_stall, fixed_k, fixed_n, tag);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset ctrl: got valid=%b last=%b busy=%b in_ready=%b want 0/0/0/1", out_valid_o, out_last_o, busy_o, in_ready_o);
        end
        checks++;
        if (out_src_o !== 32'd0 || out_dst_o !== 32'd0 || out_num_bytes_o !== 32'd0 || out_flags_o !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset data: got %h/%h/%h/%b want zeros", out_src_o, out_dst_o, out_num_bytes_o, out_flags_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_2d_basic();
        send(make_desc(32'h1000, 32'h2000, 32'd64, 32'h100, 32'h40, 32'd3, 1'b1, 3'b101), 0, -1, 0, "2d_basic");
    endtask

    task automatic test_bypass();
        send(make_desc(32'hA000, 32'hB000, 32'd16, 32'h10, 32'h20, 32'd7, 1'b0, 3'b010), 0, -1, 0, "bypass_1d");
        send(make_desc(32'hC000, 32'hD000, 32'd0, 32'h10, 32'h20, 32'd0, 1'b1, 3'b001), 0, -1, 0, "reps_zero");
    endtask

    task automatic test_backpressure();
        send(make_desc(32'h4000, 32'h8000, 32'd32, 32'h80, 32'h100, 32'd4, 1'b1, 3'b100), 0, 1, 5, "backpressure");
    endtask

    task automatic test_back_to_back();
        twod_req_t a;
        twod_req_t b;
        twod_req_t none;
        none = '0;
        a = make_desc(32'h100, 32'h200, 32'd8, 32'h8, 32'h10, 32'd2, 1'b1, 3'b011);
        b = make_desc(32'h900, 32'h700, 32'd4, 32'hFFFFFFFC, 32'h4, 32'd3, 1'b1, 3'b110);
        @(negedge clk_i);
        drive_desc(a);
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        stream(a, 1'b1, b, 0, -1, 0, "b2b_first");
        stream(b, 1'b0, none, 1, -1, 0, "b2b_second");
    endtask

    task automatic test_neg_stride();
        send(make_desc(32'h10, 32'hFFFFFFE0, 32'd16, 32'hFFFFFFF0, 32'h10, 32'd3, 1'b1, 3'b000), 0, -1, 0, "neg_wrap");
    endtask

    task automatic test_random();
        twod_req_t d;
        twod_req_t nd;
        twod_req_t none;
        bit chain;
        bit pending;
        none = '0;
        pending = 1'b0;
        d = '0;
        for (int i = 0; i < 25; i++) begin
            if (!pending) begin
                d = rand_desc();
                @(negedge clk_i);
                drive_desc(d);
                in_valid_i = 1'b1;
                @(negedge clk_i);
                in_valid_i = 1'b0;
            end
            nd = rand_desc();
            chain = ($urandom_range(0, 1) == 1) && (i != 24);
            stream(d, chain, chain ? nd : none, 3, -1, 0, "random");
            pending = chain;
            d = nd;
        end
    endtask

    task automatic test_reset_mid();
        twod_req_t d;
        d = make_desc(32'h3000, 32'h5000, 32'd128, 32'h200, 32'h200, 32'd4, 1'b1, 3'b111);
        @(negedge clk_i);
        drive_desc(d);
        in_valid_i = 1'b1;
        @(negedge clk_i);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_src_o !== 32'h3000) begin
            errors++;
            $display("[TB] FAIL rst_mid first burst: got valid=%b src=%h want 1/00003000", out_valid_o, out_src_o);
        end
        @(negedge clk_i);
        out_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_last_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid async drop: got valid=%b busy=%b last=%b want 0/0/0", out_valid_o, busy_o, out_last_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_mid residual c=%0d: got in_ready=%b valid=%b want 1/0", c, in_ready_o, out_valid_o);
            end
            @(negedge clk_i);
        end
        out_ready_i = 1'b0;
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_2d_basic();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_neg_stride();
        test_random();
        test_reset_mid();
        test_2d_basic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
